controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 150 +++++++++++++++
 tb/tb_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE and per-opcode phases (2-5 clocks per instruction).
// Outputs are combinational from the current state (plus zero/cz), forced low while reset is held; no backpressure.
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [1:0] cz,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_JAL  = 4'b0111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_NAND = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECUTE, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctl_t;

    state_t state_q, state_d;
    ctl_t   dec;
    ctl_t   ctl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_ADD, OP_NAND: state_d = S_EXECUTE;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_JAL:          state_d = S_JAL;
                    default:         state_d = S_FETCH;
                endcase
            end
            // op is re-sampled here; anything but LW/SW abandons the access
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        dec = '0;
        case (state_q)
            S_FETCH: begin
                dec.irwrite = 1'b1;
                dec.pcen    = 1'b1;
                dec.alusrcb = 2'b01;
            end
            S_DECODE: begin
                dec.alusrcb = 2'b10;
            end
            S_MEMADR: begin
                dec.alusrca = 1'b1;
                dec.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                dec.iord = 1'b1;
            end
            S_MEMWB: begin
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                dec.iord     = 1'b1;
                dec.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                dec.alusrca    = 1'b1;
                dec.alucontrol = (op == OP_NAND) ? ALU_NAND : ALU_ADD;
            end
            S_ALUWB: begin
                dec.regdst   = 1'b1;
                dec.regwrite = (cz == 2'b01) ? zero : 1'b1;
            end
            S_BRANCH: begin
                dec.alusrca    = 1'b1;
                dec.alucontrol = ALU_SUB;
                dec.pcsrc      = 2'b01;
                dec.pcen       = zero;
            end
            S_JAL: begin
                dec.pcsrc    = 2'b10;
                dec.pcen     = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    // Holding reset low must silence every enable, including the FETCH ones
    assign ctl = reset ? dec : '0;

    assign pcen       = ctl.pcen;
    assign memwrite   = ctl.memwrite;
    assign irwrite    = ctl.irwrite;
    assign regwrite   = ctl.regwrite;
    assign alusrca    = ctl.alusrca;
    assign iord       = ctl.iord;
    assign memtoreg   = ctl.memtoreg;
    assign regdst     = ctl.regdst;
    assign alusrcb    = ctl.alusrcb;
    assign pcsrc      = ctl.pcsrc;
    assign alucontrol = ctl.alucontrol;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: per-instruction phase model checked every cycle, plus literal spot checks.
module tb_controller;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_JAL  = 4'b0111;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic [3:0] op;
    logic [1:0] cz;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    ctl_t       act;

    int checks = 0;
    int errors = 0;

    logic       m_rst  = 1'b1;
    int         m_step = 0;
    logic [3:0] m_op   = 4'b0000;
    logic [1:0] m_cz   = 2'b00;
    ctl_t       obs [8];
    logic       any_rw;

    controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .cz         (cz),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    assign act = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int latency(input logic [3:0] o);
        case (o)
            OP_LW:           return 5;
            OP_SW:           return 4;
            OP_ADD, OP_NAND: return 4;
            OP_BEQ, OP_JAL:  return 3;
            default:         return 2;
        endcase
    endfunction

    function automatic logic is_alu(input logic [3:0] o);
        return (o == OP_ADD) || (o == OP_NAND);
    endfunction

    // Expected control word for clock `step` of an instruction (step 0 = FETCH)
    function automatic ctl_t model(input int step, input logic [3:0] o, input logic [1:0] c,
                                   input logic z, input logic rst);
        ctl_t e;
        e = '0;
        if (rst) return e;
        if (step == 0) begin
            e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01;
            return e;
        end
        if (step == 1) begin
            e.alusrcb = 2'b10;
            return e;
        end
        case (o)
            OP_LW, OP_SW: begin
                if (step == 2) begin
                    e.alusrca = 1'b1; e.alusrcb = 2'b10;
                end else if (o == OP_LW && step == 3) begin
                    e.iord = 1'b1;
                end else if (o == OP_LW && step == 4) begin
                    e.regwrite = 1'b1; e.memtoreg = 1'b1;
                end else if (o == OP_SW && step == 3) begin
                    e.iord = 1'b1; e.memwrite = 1'b1;
                end
            end
            OP_ADD, OP_NAND: begin
                if (step == 2) begin
                    e.alusrca = 1'b1;
                    e.alucontrol = (o == OP_NAND) ? 3'b001 : 3'b000;
                end else if (step == 3) begin
                    e.regdst = 1'b1;
                    e.regwrite = (c == 2'b01) ? z : 1'b1;
                end
            end
            OP_BEQ: begin
                e.alusrca = 1'b1; e.alucontrol = 3'b010; e.pcsrc = 2'b01; e.pcen = z;
            end
            OP_JAL: begin
                e.pcsrc = 2'b10; e.pcen = 1'b1; e.regwrite = 1'b1;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ctl_t e;
        e = model(m_step, m_op, m_cz, zero, m_rst);
        check($sformatf("op=%b step=%0d rst=%0d outputs", m_op, m_step, m_rst), act, e);
        if (!m_rst && m_step < 8) obs[m_step] = act;
    end

    // Drives op/cz/zero only where they matter; elsewhere the buses carry junk
    task automatic run_instr(input logic [3:0] o, input logic [1:0] c, input logic z, input int nsteps);
        int n;
        n = latency(o);
        if (nsteps > 0 && nsteps < n) n = nsteps;
        for (int i = 0; i < 8; i++) obs[i] = '0;
        for (int k = 0; k < n; k++) begin
            m_step = k; m_op = o; m_cz = c;
            op   = (k == 1 || (k == 2 && (is_alu(o) || o == OP_LW || o == OP_SW))) ? o : 4'($urandom);
            cz   = (k == 3 && is_alu(o)) ? c : 2'($urandom);
            zero = ((k == 2 && o == OP_BEQ) || (k == 3 && is_alu(o))) ? z : 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; op = 4'b0000; cz = 2'b00; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset held all outputs", act, 0);

        reset = 1'b1; m_rst = 1'b0; m_step = 0;
        #1;
        check("release pcen", pcen, 1);
        check("release irwrite", irwrite, 1);
        check("release alusrcb", alusrcb, 2'b01);

        run_instr(OP_ADD, 2'b00, 1'b0, 0);
        check("add execute alucontrol", obs[2].alucontrol, 3'b000);
        check("add aluwb regwrite", obs[3].regwrite, 1);
        check("add aluwb regdst", obs[3].regdst, 1);

        run_instr(OP_SW, 2'b00, 1'b0, 0);
        check("sw memadr alusrcb", obs[2].alusrcb, 2'b10);
        check("sw memwr memwrite", obs[3].memwrite, 1);
        check("sw memwr iord", obs[3].iord, 1);
        any_rw = obs[0].regwrite | obs[1].regwrite | obs[2].regwrite | obs[3].regwrite;
        check("sw never regwrite", any_rw, 0);

        run_instr(OP_LW, 2'b00, 1'b0, 0);
        check("lw memrd iord", obs[3].iord, 1);
        check("lw memwb regwrite", obs[4].regwrite, 1);
        check("lw memwb memtoreg", obs[4].memtoreg, 1);
        check("lw memwb regdst", obs[4].regdst, 0);
        check("lw back in fetch after 5", irwrite, 1);

        run_instr(OP_BEQ, 2'b00, 1'b1, 0);
        check("beq taken pcen", obs[2].pcen, 1);
        check("beq taken pcsrc", obs[2].pcsrc, 2'b01);
        run_instr(OP_BEQ, 2'b00, 1'b0, 0);
        check("beq not taken pcen", obs[2].pcen, 0);

        run_instr(OP_NAND, 2'b01, 1'b0, 0);
        check("nand execute alucontrol", obs[2].alucontrol, 3'b001);
        check("nand cz01 zero0 regwrite", obs[3].regwrite, 0);
        run_instr(OP_NAND, 2'b01, 1'b1, 0);
        check("nand cz01 zero1 regwrite", obs[3].regwrite, 1);
        run_instr(OP_ADD, 2'b10, 1'b0, 0);
        check("add cz10 regwrite", obs[3].regwrite, 1);

        run_instr(OP_JAL, 2'b00, 1'b0, 0);
        check("jal pcsrc", obs[2].pcsrc, 2'b10);
        check("jal regwrite", obs[2].regwrite, 1);

        run_instr(OP_BAD, 2'b00, 1'b0, 0);
        check("unknown op back in fetch", irwrite, 1);

        // Abort a store just as it reaches its write phase
        run_instr(OP_SW, 2'b00, 1'b0, 3);
        reset = 1'b0; m_rst = 1'b1;
        #1;
        check("async reset memwrite", memwrite, 0);
        check("async reset all outputs", act, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; m_rst = 1'b0; m_step = 0;
        #1;
        check("rerelease irwrite", irwrite, 1);
        run_instr(OP_LW, 2'b00, 1'b0, 0);
        check("lw after abort memwb regwrite", obs[4].regwrite, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
